modexp_ctrl: RTL

- Sequencer for one external `montgomery` multiplier instance. Computes X^E mod M by left-to-right square-and-multiply.
- Issues start pulses to the multiplier, steers its operands, and captures its results.
- Sits between the RSA top-level register interface and the multiplier; it owns the multiplier exclusively.

---
 rtl/modexp_pkg.sv | 24 ++
 rtl/modexp_ctrl_exp_scan.sv | 44 ++++
 rtl/modexp_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/modexp_pkg.sv
// modexp_pkg: shared types for the modular-exponentiation sequencer.
// Holds the FSM state encoding, operand selects and the multiplier width.
package modexp_pkg;

    localparam int MONT_WIDTH = 512;

    typedef enum logic [2:0] {
        IDLE,
        TOMONT,
        SQUARE,
        MULT,
        FROMMONT,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_A,
        OP_XT,
        OP_X,
        OP_R2,
        OP_ONE
    } opsel_t;

endpackage

// File: rtl/modexp_ctrl_exp_scan.sv
// exp_scan: captured exponent plus the MSB-first bit down-counter.
// The length is clamped to EXP_WIDTH when it is loaded.
module exp_scan #(
    parameter int EXP_WIDTH = 512,
    parameter int ELEN_W    = 10
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_load,
    input  logic [EXP_WIDTH-1:0] i_e,
    input  logic [ELEN_W-1:0]    i_len,
    input  logic                 i_dec,
    output logic                 o_cur_bit,
    output logic                 o_last,
    output logic                 o_zero
);

    localparam int PW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    logic [EXP_WIDTH-1:0] r_e;
    logic [ELEN_W-1:0]    r_idx;
    logic [ELEN_W-1:0]    w_len;
    logic [PW-1:0]        w_pos;

    assign w_len = (i_len > ELEN_W'(EXP_WIDTH)) ? ELEN_W'(EXP_WIDTH) : i_len;
    assign w_pos = PW'(r_idx - ELEN_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_e   <= '0;
            r_idx <= '0;
        end else if (i_load) begin
            r_e   <= i_e;
            r_idx <= w_len;
        end else if (i_dec && (r_idx != '0)) begin
            r_idx <= r_idx - ELEN_W'(1);
        end
    end

    assign o_zero    = (r_idx == '0);
    assign o_last    = (r_idx == ELEN_W'(1));
    assign o_cur_bit = o_zero ? 1'b0 : r_e[w_pos];

endmodule

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer for one Montgomery
// multiplier. Define MODEXP_PERF_CNT_EN to add perf_ops/perf_cycles counters.
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int WIDTH     = MONT_WIDTH,
    parameter int EXP_WIDTH = 512,
    parameter int ELEN_W    = 10
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [ELEN_W-1:0]    in_e_len,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_r2,
    output logic                 mont_start,
    output logic [WIDTH-1:0]     mont_a,
    output logic [WIDTH-1:0]     mont_b,
    output logic [WIDTH-1:0]     mont_m,
    input  logic [WIDTH-1:0]     mont_result,
    input  logic                 mont_done,
    output logic [WIDTH-1:0]     result,
    output logic                 busy,
    output logic                 done
`ifdef MODEXP_PERF_CNT_EN
    ,
    output logic [15:0]          perf_ops,
    output logic [31:0]          perf_cycles
`endif
);

    state_t           r_state;
    state_t           w_next;
    opsel_t           w_sel_a;
    opsel_t           w_sel_b;
    logic             w_op;
    logic             w_op_done;
    logic             w_accept;
    logic             w_dec;
    logic             w_cur_bit;
    logic             w_last;
    logic             w_zero;
    logic             r_wait;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_r2;
    logic [WIDTH-1:0] r_xt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_result;

    function automatic logic [WIDTH-1:0] pick(
        input opsel_t           s,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] xt,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] r2
    );
        logic [WIDTH-1:0] v;
        v = '0;
        unique case (s)
            OP_A:    v = a;
            OP_XT:   v = xt;
            OP_X:    v = x;
            OP_R2:   v = r2;
            OP_ONE:  v = WIDTH'(1);
            default: v = '0;
        endcase
        return v;
    endfunction

    assign w_accept  = (r_state == IDLE) && start;
    assign w_op_done = w_op && r_wait && mont_done;
    assign w_dec     = w_op_done &&
                       (((r_state == SQUARE) && !w_cur_bit) ||
                        (r_state == MULT));

    exp_scan #(
        .EXP_WIDTH (EXP_WIDTH),
        .ELEN_W    (ELEN_W)
    ) u_scan (
        .clk       (clk),
        .resetn    (resetn),
        .i_load    (w_accept),
        .i_e       (in_e),
        .i_len     (in_e_len),
        .i_dec     (w_dec),
        .o_cur_bit (w_cur_bit),
        .o_last    (w_last),
        .o_zero    (w_zero)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (start) w_next = TOMONT;
            TOMONT:   if (w_op_done) w_next = w_zero ? FROMMONT : SQUARE;
            SQUARE:   if (w_op_done)
                          w_next = w_cur_bit ? MULT :
                                   (w_last ? FROMMONT : SQUARE);
            MULT:     if (w_op_done) w_next = w_last ? FROMMONT : SQUARE;
            FROMMONT: if (w_op_done) w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_sel_a    = OP_A;
        w_sel_b    = OP_A;
        w_op       = 1'b0;
        done       = 1'b0;
        unique case (r_state)
            TOMONT: begin
                w_sel_a = OP_X;
                w_sel_b = OP_R2;
                w_op    = 1'b1;
            end
            SQUARE:   w_op = 1'b1;
            MULT: begin
                w_sel_b = OP_XT;
                w_op    = 1'b1;
            end
            FROMMONT: begin
                w_sel_b = OP_ONE;
                w_op    = 1'b1;
            end
            DONE:     done = 1'b1;
            default: ;
        endcase
        busy       = w_op;
        mont_start = w_op && !r_wait;
    end

    // Operands come only from registers, so they hold steady across the wait.
    assign mont_a = w_op ? pick(w_sel_a, r_a, r_xt, r_x, r_r2) : '0;
    assign mont_b = w_op ? pick(w_sel_b, r_a, r_xt, r_x, r_r2) : '0;
    assign mont_m = r_m;
    assign result = r_result;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wait   <= 1'b0;
            r_x      <= '0;
            r_m      <= '0;
            r_r      <= '0;
            r_r2     <= '0;
            r_xt     <= '0;
            r_a      <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_x  <= in_x;
                r_m  <= in_m;
                r_r  <= in_r;
                r_r2 <= in_r2;
            end
            if (mont_start)     r_wait <= 1'b1;
            else if (w_op_done) r_wait <= 1'b0;
            if (w_op_done) begin
                unique case (r_state)
                    TOMONT: begin
                        r_xt <= mont_result;
                        r_a  <= r_r;
                    end
                    SQUARE, MULT: r_a      <= mont_result;
                    FROMMONT:     r_result <= mont_result;
                    default: ;
                endcase
            end
        end
    end

`ifdef MODEXP_PERF_CNT_EN
    logic [15:0] r_perf_ops;
    logic [31:0] r_perf_cycles;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_ops    <= '0;
            r_perf_cycles <= '0;
        end else if (w_accept) begin
            r_perf_ops    <= '0;
            r_perf_cycles <= '0;
        end else begin
            if (mont_start && (r_perf_ops != '1))
                r_perf_ops <= r_perf_ops + 16'd1;
            if (busy && (r_perf_cycles != '1))
                r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign perf_ops    = r_perf_ops;
    assign perf_cycles = r_perf_cycles;
`else
    // Counters are not built in this configuration.
`endif

endmodule
